// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the 5-stage RISC-V pipeline.
// Takes each instruction leaving MEM with its ALU result. For loads it waits
// for the data memory response, then extracts, aligns and extends the returned
// data. Drives a registered register-file write port, a retire pulse and a
// 64-bit retired-instruction counter.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i / ready_o       MEM->WB handshake (ready_o low while a load waits)
//   instr_rdata_i           instruction word (opcode, rd, funct3 decoded here)
//   alu_result_i            ALU/CSR/link result
//   addr_lsb_i              load address bits [1:0]
//   data_rvalid_i/rdata_i   data memory read response
//   rf_we_o/waddr_o/wdata_o registered register-file write port
//   retire_o, instret_o     retire pulse and retired-instruction counter
//   err_o                   sticky: stray rvalid or illegal load funct3
module wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [31:0]               instr_rdata_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [1:0]                addr_lsb_i,
    input  logic                      data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      retire_o,
    output logic [63:0]               instret_o,
    output logic                      err_o
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    typedef struct packed {
        logic                      we;
        logic [REG_ADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0]     wdata;
        logic                      retire;
    } wb_t;

    state_t                    state_q, state_d;
    wb_t                       wb_d, wb_q;
    logic                      err_set, ld_capture;
    logic [REG_ADDR_WIDTH-1:0] ld_rd_q;
    logic [2:0]                ld_f3_q;
    logic [1:0]                ld_lsb_q;
    logic [63:0]               instret_q;
    logic                      err_q;

    logic [6:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [2:0]                funct3;
    logic                      accept, is_load;

    assign opcode  = instr_rdata_i[6:0];
    assign rd      = instr_rdata_i[7 +: REG_ADDR_WIDTH];
    assign funct3  = instr_rdata_i[14:12];
    assign ready_o = (state_q == IDLE);
    assign accept  = valid_i && ready_o;
    assign is_load = (opcode == OPC_LOAD);

    function automatic logic writes_rd(input logic [6:0] op, input logic [2:0] f3);
        unique case (op)
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
            OPC_SYSTEM: writes_rd = (f3 != 3'b000);   // CSR ops write, ECALL/EBREAK do not
            default:    writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic load_legal(input logic [2:0] f3);
        load_legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    // Halfword select uses lsb[1] only; misalignment is trapped upstream.
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [2:0] f3,
                                                      input logic [1:0] lsb,
                                                      input logic [DATA_WIDTH-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lsb, 3'b000} +: 8];
        h = w[{lsb[1], 4'b0000} +: 16];
        unique case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b010:  extract = w;
            3'b100:  extract = {24'b0, b};
            3'b101:  extract = {16'b0, h};
            default: extract = '0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (accept && is_load && !data_rvalid_i) state_d = WAIT_LOAD;
            WAIT_LOAD: if (data_rvalid_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic: next writeback word, error set, load-field capture
    always_comb begin
        wb_d       = '0;
        err_set    = 1'b0;
        ld_capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_load) begin
                        wb_d.retire = 1'b1;
                        wb_d.we     = writes_rd(opcode, funct3) && (rd != '0);
                    end else if (data_rvalid_i) begin
                        // Response already here: finish the load like an ALU op.
                        wb_d.retire = 1'b1;
                        wb_d.we     = load_legal(funct3) && (rd != '0);
                        err_set     = !load_legal(funct3);
                    end else begin
                        ld_capture = 1'b1;
                    end
                    if (wb_d.we) begin
                        wb_d.waddr = rd;
                        wb_d.wdata = is_load ? extract(funct3, addr_lsb_i, data_rdata_i)
                                             : alu_result_i;
                    end
                end
                // Response with no load to consume it
                if (data_rvalid_i && !(accept && is_load)) err_set = 1'b1;
            end
            WAIT_LOAD: begin
                if (data_rvalid_i) begin
                    wb_d.retire = 1'b1;
                    wb_d.we     = load_legal(ld_f3_q) && (ld_rd_q != '0);
                    err_set     = !load_legal(ld_f3_q);
                    if (wb_d.we) begin
                        wb_d.waddr = ld_rd_q;
                        wb_d.wdata = extract(ld_f3_q, ld_lsb_q, data_rdata_i);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_q      <= '0;
            instret_q <= '0;
            err_q     <= 1'b0;
            ld_rd_q   <= '0;
            ld_f3_q   <= '0;
            ld_lsb_q  <= '0;
        end else begin
            wb_q <= wb_d;
            if (wb_d.retire) instret_q <= instret_q + 64'd1;
            if (err_set)     err_q     <= 1'b1;
            if (ld_capture) begin
                ld_rd_q  <= rd;
                ld_f3_q  <= funct3;
                ld_lsb_q <= addr_lsb_i;
            end
        end
    end

    assign rf_we_o    = wb_q.we;
    assign rf_waddr_o = wb_q.waddr;
    assign rf_wdata_o = wb_q.wdata;
    assign retire_o   = wb_q.retire;
    assign instret_o  = instret_q;
    assign err_o      = err_q;

endmodule
